gpio_access_arbiter: RTL and testbench
======================================

Name: gpio_access_arbiter

Overview:
- Shares the project-wide GPIO pin bank between NUM_REQ requesters.
- Each requester issues a masked write of output value and direction, and gets back a response carrying the synchronised pin input state.
- Arbitration is round-robin, with one access in flight at a time and a programmable settle delay before sampling.
- Sits between the core's GPIO-using sub-blocks and the pad ring. GPIO width is the global GPIO parameter from the core parameter package.

Parameters:
- GPIO, proj_param_pkg::PROJ_GPIO (via core param package), pin bank width in bits.
- NUM_REQ, 4, number of requesters (≥2).
- SETTLE_CYCLES, 2, wait cycles after pins update before sampling gpio_in (0..255).
- IDW, $clog2(NUM_REQ), requester-id width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester access request.
- req_ready  out  NUM_REQ  per-requester accept, at most one bit high.
- req_data  in  NUM_REQ*GPIO  output values; slice i belongs to requester i.
- req_mask  in  NUM_REQ*GPIO  bits to modify; slice i.
- req_oe  in  NUM_REQ*GPIO  output enables applied under the mask; slice i.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_id  out  IDW  requester the response belongs to.
- rsp_rdata  out  GPIO  synchronised pin input state sampled after the settle period.
- gpio_out  out  GPIO  registered pin output values.
- gpio_oe  out  GPIO  registered pin output enables.
- gpio_in  in  GPIO  asynchronous pin inputs.

Behaviour:
- Reset values:
  - gpio_out=0, gpio_oe=0, rsp_valid=0, rsp_id=0, rsp_rdata=0.
  - state=IDLE, rr_ptr=NUM_REQ-1, so requester 0 has first priority.
  - Both synchroniser stages=0.
- Input synchroniser: gpio_in passes through a 2-flop synchroniser (gin_s); it runs continuously.
- req_ready is combinational:
  - High only in IDLE, for the granted index g.
  - g = first i with req_valid[i], searching from rr_ptr+1 and wrapping modulo NUM_REQ.
  - Acceptance = req_valid[g] & req_ready[g], in cycle T. A request may drop before acceptance without side effects.
- State machine:
  - IDLE: on acceptance, latch data/mask/oe slices and id=g, set rr_ptr=g, go to APPLY. Otherwise stay in IDLE.
  - APPLY (1 cycle, T+1): at the end of the cycle, gpio_out = (gpio_out & ~mask) | (data & mask) and gpio_oe = (gpio_oe & ~mask) | (oe & mask). New values are visible from T+2.
    - If SETTLE_CYCLES=0, go to RESP.
    - Otherwise load cnt=SETTLE_CYCLES-1 and go to SETTLE.
  - SETTLE: decrement cnt each cycle; when cnt==0, go to RESP. Total cycles spent in SETTLE = SETTLE_CYCLES.
  - RESP:
    - Entry cycle: capture rsp_rdata=gin_s and rsp_id=id; rsp_valid rises at cycle T+2+SETTLE_CYCLES.
    - Hold rsp_valid/rsp_id/rsp_rdata stable until rsp_valid & rsp_ready, then deassert rsp_valid and go to IDLE.
    - rsp_rdata is not re-sampled while waiting.
- Throughput: a new accept is possible at the earliest in the cycle after the response handshake. No requests are accepted outside IDLE (req_ready=0).
- mask=0: no pin change. The access degenerates to a read with identical timing.
- Simultaneous requests: exactly one is granted per IDLE cycle. Priority rotates so that a continuously requesting requester is served within NUM_REQ accesses.
- gpio_out/gpio_oe hold their last values between accesses and never change outside APPLY.
- Reset asserted mid-operation: immediate return to reset values, and the in-flight access is lost with no response. This includes pins driven back to 0 with oe=0.
- rsp_ready held high permanently: the response is accepted in its first cycle, giving a minimum access period of 3+SETTLE_CYCLES cycles.

Test Plan:
Setup for all scenarios: GPIO=8, NUM_REQ=3, SETTLE_CYCLES=2.
1. After reset, req0 writes data=0xA5, mask=0xFF, oe=0x0F, accepted at T → gpio_out=0xA5, gpio_oe=0x0F at T+2; rsp_valid at T+4 with rsp_id=0 and rsp_rdata=gpio_in value synchronised by then.
2. req0/req1/req2 all valid continuously, rsp_ready=1 → grant order 0,1,2,0,…; each req_ready is a single-cycle pulse; 5-cycle access period.
3. gpio_out=0xF0, then req1 writes data=0x0F, mask=0x3C → gpio_out=0xCC (0x0F & 0x3C = 0x0C merged with 0xF0 & ~0x3C = 0xC0); unmasked bits unchanged.
4. rsp_ready held low 10 cycles while gpio_in toggles → rsp_valid/rsp_id/rsp_rdata stable throughout; req_ready stays 0; next grant only after the handshake.
5. rst_n asserted during SETTLE after writing 0xFF → gpio_out=0, gpio_oe=0, rsp_valid=0 immediately; next grant after release goes to requester 0.
6. req2 mask=0, data=0xFF → gpio_out unchanged; response still at T+4 with the current synchronised gpio_in.

Source files
------------

// File: rtl/gpio_access_arbiter.sv
// Round-robin arbiter sharing the GPIO pin bank between NUM_REQ requesters.
// One masked write plus a settled, synchronised input sample per access.
module gpio_access_arbiter #(
    parameter int GPIO          = 8,   // project GPIO bank width
    parameter int NUM_REQ       = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int IDW           = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*GPIO-1:0] req_data,
    input  logic [NUM_REQ*GPIO-1:0] req_mask,
    input  logic [NUM_REQ*GPIO-1:0] req_oe,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [GPIO-1:0]         rsp_rdata,
    output logic [GPIO-1:0]         gpio_out,
    output logic [GPIO-1:0]         gpio_oe,
    input  logic [GPIO-1:0]         gpio_in
);

    // state    | meaning
    // S_IDLE   | offer grant to next requester in round-robin order
    // S_APPLY  | merge latched data/oe into the pins under the mask
    // S_SETTLE | wait SETTLE_CYCLES for the pads to settle
    // S_RESP   | hold response until rsp_ready
    typedef enum logic [1:0] {S_IDLE, S_APPLY, S_SETTLE, S_RESP} state_t;

    localparam logic [7:0] SETTLE_LD = (SETTLE_CYCLES > 0) ? 8'(SETTLE_CYCLES - 1) : 8'd0;

    state_t          r_state, w_state_nxt;
    logic [GPIO-1:0] r_gin_s1, r_gin_s2;
    logic [IDW-1:0]  r_rr_ptr, r_id, r_rsp_id;
    logic [IDW-1:0]  w_gnt_idx;
    logic            w_gnt_vld;
    logic [GPIO-1:0] r_data, r_mask, r_oe;
    logic [GPIO-1:0] r_gpio_out, r_gpio_oe, r_rsp_rdata;
    logic            r_rsp_valid;
    logic [7:0]      r_cnt;
    logic            w_accept, w_apply, w_to_resp, w_rsp_done;

    // Scan from the requester after the last grant, wrapping; the lowest
    // distance wins, so the descending loop leaves the nearest one assigned.
    always_comb begin : p_grant
        int idx;
        idx       = 0;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = IDW'(idx);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        w_accept    = 1'b0;
        w_apply     = 1'b0;
        w_to_resp   = 1'b0;
        w_rsp_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_vld) begin
                    req_ready[w_gnt_idx] = 1'b1;
                    w_accept             = 1'b1;
                    w_state_nxt          = S_APPLY;
                end
            end
            S_APPLY: begin
                w_apply = 1'b1;
                if (SETTLE_CYCLES == 0) begin
                    w_to_resp   = 1'b1;
                    w_state_nxt = S_RESP;
                end else begin
                    w_state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_cnt == 8'd0) begin
                    w_to_resp   = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_rsp_done  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_gin_s1    <= '0;
            r_gin_s2    <= '0;
            r_rr_ptr    <= IDW'(NUM_REQ - 1);
            r_id        <= '0;
            r_data      <= '0;
            r_mask      <= '0;
            r_oe        <= '0;
            r_cnt       <= '0;
            r_gpio_out  <= '0;
            r_gpio_oe   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_gin_s1 <= gpio_in;
            r_gin_s2 <= r_gin_s1;
            r_state  <= w_state_nxt;
            if (w_accept) begin
                r_rr_ptr <= w_gnt_idx;
                r_id     <= w_gnt_idx;
                r_data   <= req_data[w_gnt_idx*GPIO +: GPIO];
                r_mask   <= req_mask[w_gnt_idx*GPIO +: GPIO];
                r_oe     <= req_oe[w_gnt_idx*GPIO +: GPIO];
            end
            if (w_apply) begin
                r_gpio_out <= (r_gpio_out & ~r_mask) | (r_data & r_mask);
                r_gpio_oe  <= (r_gpio_oe & ~r_mask) | (r_oe & r_mask);
                r_cnt      <= SETTLE_LD;
            end else if (r_state == S_SETTLE && r_cnt != 8'd0) begin
                r_cnt <= r_cnt - 8'd1;
            end
            // Sample once on entry to S_RESP; held while the consumer stalls.
            if (w_to_resp) begin
                r_rsp_valid <= 1'b1;
                r_rsp_id    <= r_id;
                r_rsp_rdata <= r_gin_s2;
            end else if (w_rsp_done) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_rdata = r_rsp_rdata;
    assign gpio_out  = r_gpio_out;
    assign gpio_oe   = r_gpio_oe;

endmodule

// File: tb/tb_gpio_access_arbiter.sv
// Bench for gpio_access_arbiter: transaction-timestamp model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_gpio_access_arbiter;
    localparam int G   = 8;
    localparam int NR  = 3;
    localparam int S   = 2;
    localparam int IDW = 2;
    localparam int HN  = 4096;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_ready;
    logic [NR*G-1:0] req_data = '0;
    logic [NR*G-1:0] req_mask = '0;
    logic [NR*G-1:0] req_oe = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic [IDW-1:0]  rsp_id;
    logic [G-1:0]    rsp_rdata;
    logic [G-1:0]    gpio_out, gpio_oe;
    logic [G-1:0]    gpio_in = 8'h3C;

    gpio_access_arbiter #(.GPIO(G), .NUM_REQ(NR), .SETTLE_CYCLES(S), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_mask(req_mask), .req_oe(req_oe),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
        .gpio_out(gpio_out), .gpio_oe(gpio_oe), .gpio_in(gpio_in)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Model: one access outstanding, described by its accept cycle m_t.
    bit           m_busy = 1'b0;
    int           m_t = 0, m_id = 0, m_ptr = NR - 1;
    logic [G-1:0] m_out = '0, m_oe = '0, m_d = '0, m_m = '0, m_e = '0;
    logic [G-1:0] hist [HN];

    int lit0_t = -1000, lit1_t = -1000, lit3_t = -1000, lit4_t = -1000;
    int lit5_t = -1000, lit5_r = -1000, lit6_t = -1000, tmp_t = 0;
    bit s2_on = 1'b0;
    int s2_n = 0, s2_last = 0;
    logic [31:0] s2_ord [3] = '{32'd1, 32'd2, 32'd4};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    function automatic int grant(input logic [NR-1:0] v, input int ptr);
        for (int k = 1; k <= NR; k++)
            if (v[(ptr + k) % NR]) return (ptr + k) % NR;
        return -1;
    endfunction

    initial forever begin : compare
        int c, g;
        logic [NR-1:0] exp_rdy;
        bit exp_rv;
        @(negedge clk);
        c = cyc;
        hist[c % HN] = rst_n ? gpio_in : 8'h00;
        if (!rst_n) begin
            m_busy = 1'b0; m_ptr = NR - 1; m_out = '0; m_oe = '0;
            exp_rv = 1'b0;
        end else begin
            if (m_busy && c == m_t + 2) begin
                m_out = (m_out & ~m_m) | (m_d & m_m);
                m_oe  = (m_oe & ~m_m) | (m_e & m_m);
            end
            exp_rv = m_busy && (c >= m_t + 2 + S);
        end
        g = grant(req_valid, m_ptr);
        exp_rdy = '0;
        if (!m_busy && g >= 0) exp_rdy[g] = 1'b1;
        chk("gpio_out", 32'(gpio_out), 32'(m_out));
        chk("gpio_oe", 32'(gpio_oe), 32'(m_oe));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (exp_rv) begin
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
            chk("rsp_rdata", 32'(rsp_rdata), 32'(hist[(m_t + S - 1) % HN]));
        end
        if (!rst_n) begin
            chk("rst_rsp_id", 32'(rsp_id), 32'd0);
            chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        end else if (exp_rv && rsp_ready) begin
            m_busy = 1'b0;
        end else if (!m_busy && g >= 0) begin
            m_busy = 1'b1; m_t = c; m_id = g; m_ptr = g;
            m_d = req_data[g*G +: G]; m_m = req_mask[g*G +: G]; m_e = req_oe[g*G +: G];
        end

        // Hand-computed expectations pinning the model.
        if (c == lit0_t) begin
            chk("reset_out", 32'(gpio_out), 32'd0);
            chk("reset_oe", 32'(gpio_oe), 32'd0);
            chk("reset_rv", 32'(rsp_valid), 32'd0);
        end
        if (c == lit1_t + 2) begin
            chk("s1_out", 32'(gpio_out), 32'hA5);
            chk("s1_oe", 32'(gpio_oe), 32'h0F);
        end
        if (c == lit1_t + 3) chk("s1_rv_early", 32'(rsp_valid), 32'd0);
        if (c == lit1_t + 4) begin
            chk("s1_rv", 32'(rsp_valid), 32'd1);
            chk("s1_id", 32'(rsp_id), 32'd0);
            chk("s1_rdata", 32'(rsp_rdata), 32'h3C);
        end
        if (s2_on && rst_n && req_ready != '0) begin
            chk("s2_order", 32'(req_ready), s2_ord[s2_n % 3]);
            if (s2_n > 0) chk("s2_period", c - s2_last, 32'd5);
            s2_last = c;
            s2_n++;
        end
        if (c == lit3_t + 2) begin
            chk("s3_out", 32'(gpio_out), 32'hCC);
            chk("s3_oe", 32'(gpio_oe), 32'h3C);
        end
        if (c == lit4_t + 14) begin
            chk("s4_rv", 32'(rsp_valid), 32'd1);
            chk("s4_id", 32'(rsp_id), 32'd2);
            chk("s4_rdy", 32'(req_ready), 32'd0);
        end
        if (c == lit4_t + 15) chk("s4_next", 32'(req_ready), 32'd1);
        if (c == lit5_t + 2) begin
            chk("s5_out", 32'(gpio_out), 32'd0);
            chk("s5_oe", 32'(gpio_oe), 32'd0);
            chk("s5_rv", 32'(rsp_valid), 32'd0);
        end
        if (c == lit5_r) chk("s5_gnt", 32'(req_ready), 32'd1);
        if (c == lit6_t + 2) begin
            chk("s6_out", 32'(gpio_out), 32'h5A);
            chk("s6_oe", 32'(gpio_oe), 32'h33);
        end
        if (c == lit6_t + 4) begin
            chk("s6_rv", 32'(rsp_valid), 32'd1);
            chk("s6_id", 32'(rsp_id), 32'd2);
            chk("s6_rdata", 32'(rsp_rdata), 32'h96);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (m_busy || !rst_n) begin
            tick(1);
            n++;
            if (n > 100) begin
                $display("FAIL wait_idle: still busy after %0d cycles, limit 100", n);
                $fatal(1, "bench stopped");
            end
        end
    endtask

    task automatic issue(input int id, input logic [7:0] d, input logic [7:0] m,
                         input logic [7:0] e, output int t);
        wait_idle();
        req_data[id*G +: G] = d;
        req_mask[id*G +: G] = m;
        req_oe[id*G +: G]   = e;
        req_valid = '0;
        req_valid[id] = 1'b1;
        t = cyc;
        tick(1);
        req_valid = '0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        tick(1);
        lit0_t = cyc;
        tick(2);
        rst_n = 1'b1;
        tick(2);

        issue(0, 8'hA5, 8'hFF, 8'h0F, lit1_t);
        wait_idle();

        rst_n = 1'b0;
        tick(2);
        req_data = 24'h123456; req_mask = 24'hFFFFFF; req_oe = 24'h0F0F0F;
        rst_n = 1'b1;
        req_valid = '1;
        s2_on = 1'b1;
        tick(32);
        req_valid = '0;
        s2_on = 1'b0;
        wait_idle();

        issue(0, 8'hF0, 8'hFF, 8'h00, tmp_t);
        issue(1, 8'h0F, 8'h3C, 8'h3C, lit3_t);
        wait_idle();

        rsp_ready = 1'b0;
        issue(2, 8'h11, 8'h0F, 8'h0F, lit4_t);
        req_valid = 3'b011;
        for (int i = 0; i < 13; i++) begin
            gpio_in = 8'($urandom);
            tick(1);
        end
        rsp_ready = 1'b1;
        tick(1);
        gpio_in = 8'h96;
        tick(1);
        req_valid = '0;
        wait_idle();

        issue(0, 8'hFF, 8'hFF, 8'hFF, lit5_t);
        tick(1);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        req_valid = '1;
        lit5_r = cyc;
        tick(1);
        req_valid = '0;
        wait_idle();

        issue(0, 8'h5A, 8'hFF, 8'h33, tmp_t);
        issue(2, 8'hFF, 8'h00, 8'hFF, lit6_t);
        wait_idle();

        for (int i = 0; i < 3000; i++) begin
            req_valid = NR'($urandom);
            req_data  = 24'($urandom);
            req_mask  = 24'($urandom);
            req_oe    = 24'($urandom);
            rsp_ready = ($urandom_range(3) != 0);
            gpio_in   = 8'($urandom);
            rst_n     = ($urandom_range(399) != 0);
            tick(1);
        end
        rst_n = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        tick(10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
